// File: rtl/and_arb_pkg.sv
// Shared definitions for the round-robin AND arbiter.
//   arb_state_e : output register occupancy (EMPTY / FULL)
//   id_w(n)     : requester-id width for n requesters, never below 1
package and_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and_unit_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector
//   ptr        : highest-priority index this cycle
//   gnt_onehot : one-hot grant (zero when no request)
//   gnt_idx    : binary index of the grant
//   any        : at least one request present
module rr_pick
  import and_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic [NREQ-1:0]   hi_mask;
  logic [2*NREQ-1:0] dbl;
  int                hit;

  // Lower half holds requests at or above ptr, upper half holds all of them;
  // the lowest set bit of the concatenation is the wrapped round-robin winner.
  always_comb begin
    for (int i = 0; i < NREQ; i++) hi_mask[i] = (ID_W'(i) >= ptr);
    dbl = {req, req & hi_mask};
    hit = 0;
    for (int j = 2*NREQ-1; j >= 0; j--) if (dbl[j]) hit = j;
    gnt_idx = (hit >= NREQ) ? ID_W'(hit - NREQ) : ID_W'(hit);
    any     = |req;
    for (int i = 0; i < NREQ; i++) gnt_onehot[i] = any && (gnt_idx == ID_W'(i));
  end

endmodule

// File: rtl/corebit_and.sv
// Single-bit AND cell, the primitive of the shared datapath slice.
//   in0, in1 : operand bits
//   out      : in0 & in1
module corebit_and (
  input  logic in0,
  input  logic in1,
  output logic out
);
  assign out = in0 & in1;
endmodule

// File: rtl/and_unit_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise-AND slice among NREQ requesters,
// with a one-entry registered result tagged by requester id.
//   CLK, RESETN          : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   O_valid/O_ready      : result handshake
//   O, O_id              : result a&b and the id of the requester that produced it
//   busy                 : mirrors O_valid
module and_unit_rr_arbiter
  import and_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  O_valid,
  input  logic                  O_ready,
  output logic [WIDTH-1:0]      O,
  output logic [ID_W-1:0]       O_id,
  output logic                  busy
);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [NREQ-1:0]  gnt_onehot;
  logic [ID_W-1:0]  gnt_idx;
  logic             any;
  logic             can_accept, xfer;
  logic [WIDTH-1:0] a_sel, b_sel, and_out;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // RESETN gating keeps req_ready low through reset cycles.
  assign can_accept = (state == EMPTY) || O_ready;
  assign xfer       = RESETN && can_accept && any;
  assign req_ready  = xfer ? gnt_onehot : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_and
    corebit_and u_and (.in0(a_sel[b]), .in1(b_sel[b]), .out(and_out[b]));
  end

  // A new accept wins over a drain, so FULL is kept when both happen.
  always_comb begin
    state_nxt = state;
    if (xfer)                        state_nxt = FULL;
    else if (state == FULL && O_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= EMPTY;
      ptr   <= '0;
      O     <= '0;
      O_id  <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        O    <= and_out;
        O_id <= gnt_idx;
        ptr  <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign O_valid = (state == FULL);
  assign busy    = O_valid;

endmodule

// File: tb/tb_and_unit_rr_arbiter.sv
module tb_and_unit_rr_arbiter;

  localparam int NREQ = 4, WIDTH = 4, ID_W = 2;

  logic                  CLK = 1'b0;
  logic                  RESETN;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  O_valid, O_ready, busy;
  logic [WIDTH-1:0]      O;
  logic [ID_W-1:0]       O_id;

  int tests = 0, fails = 0;

  and_unit_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .O_valid(O_valid), .O_ready(O_ready),
    .O(O), .O_id(O_id), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; registered outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] o, input logic [1:0] id);
    chk({tag, ".O_valid"}, 32'(O_valid), 32'(v));
    chk({tag, ".busy"},    32'(busy),    32'(v));
    chk({tag, ".O"},       32'(O),       32'(o));
    chk({tag, ".O_id"},    32'(O_id),    32'(id));
  endtask

  initial begin
    // requester i produces (i+1) with these operands
    req_a = 16'h4321; req_b = 16'hFFFF;
    RESETN = 1'b0; req_valid = 4'hF; O_ready = 1'b1;

    // 1 reset with all requesters valid
    tick(); #1;
    chk("rst1.ready", 32'(req_ready), 32'h0);
    chk_out("rst1", 1'b0, 4'h0, 2'd0);
    tick(); #1;
    chk("rst2.ready", 32'(req_ready), 32'h0);
    chk_out("rst2", 1'b0, 4'h0, 2'd0);
    RESETN = 1'b1; #1;
    chk("first.ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("first", 1'b1, 4'h1, 2'd0);             // ptr -> 1

    // drain with no request: O/O_id keep their values
    req_valid = 4'h0; #1;
    chk("drain.ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 4'h1, 2'd0);

    // 2 single request on id 2: C & A = 8
    req_a = 16'h0C00; req_b = 16'h0A00; req_valid = 4'b0100; #1;
    chk("single.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("single", 1'b1, 4'h8, 2'd2);            // ptr -> 3

    // 3 all valid, 8 back-to-back transfers from ptr 3: 3,0,1,2,3,0,1,2
    req_a = 16'h4321; req_b = 16'hFFFF; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      automatic int g = (3 + k) % 4;
      #1;
      chk($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(1 << g));
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, 4'(g + 1), 2'(g));
    end

    // 4 backpressure while FULL (O=3, id=2), ptr=3
    O_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.ready", k), 32'(req_ready), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", k), 1'b1, 4'h3, 2'd2);
    end
    O_ready = 1'b1; #1;
    chk("bp_rel.ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("bp_rel", 1'b1, 4'h4, 2'd3);            // ptr -> 0

    // 5 wrap and skip: bring ptr to 3, then only req 1
    req_valid = 4'b0100; #1;
    chk("wrap_pre.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("wrap_pre", 1'b1, 4'h3, 2'd2);          // ptr -> 3
    req_valid = 4'b0010; #1;
    chk("skip1.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("skip1", 1'b1, 4'h2, 2'd1);             // ptr -> 2
    req_valid = 4'b1001; #1;
    chk("skip3.ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("skip3", 1'b1, 4'h4, 2'd3);             // ptr -> 0 (wrap)
    #1;
    chk("skip0.ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("skip0", 1'b1, 4'h1, 2'd0);             // ptr -> 1

    // 6 reset while FULL and stalled
    req_valid = 4'b0100; #1;
    tick();
    chk_out("pre_rst", 1'b1, 4'h3, 2'd2);           // ptr -> 3
    O_ready = 1'b0; req_valid = 4'hF; RESETN = 1'b0; #1;
    chk("mid_rst.ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 4'h0, 2'd0);
    RESETN = 1'b1; O_ready = 1'b1; #1;
    chk("post_rst.ready", 32'(req_ready), 32'b0001); // ptr back to 0
    tick();
    chk_out("post_rst", 1'b1, 4'h1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
